// File: rtl/prl_rx_pe_dispatch_if.sv
`default_nettype none
// ============================================================================
// prl_rx_pe_dispatch_if
// PRL RX message strobe in, PE presentation out, queue status.
// Revision: 1.0
// ============================================================================
interface prl_rx_pe_dispatch_if #(
    parameter int DEPTH  = 4,
    parameter int DROP_W = 8
);
    logic                     msg_vld;
    logic [6:0]               msg_type;
    logic [2:0]               msg_sop;
    logic [22:0]              msg_info;
    logic                     pe_ack;
    logic                     flush;
    logic                     err_clr;
    logic                     pl2pe_rx_en;
    logic [6:0]               pl2pe_rx_type;
    logic [2:0]               pl2pe_rx_sop_type;
    logic [22:0]              pl2pe_rx_info;
    logic [$clog2(DEPTH):0]   q_count;
    logic                     ovf_err;
    logic [DROP_W-1:0]        drop_cnt;

    modport master (
        output msg_vld, msg_type, msg_sop, msg_info, pe_ack, flush, err_clr,
        input  pl2pe_rx_en, pl2pe_rx_type, pl2pe_rx_sop_type, pl2pe_rx_info,
        input  q_count, ovf_err, drop_cnt
    );

    modport slave (
        input  msg_vld, msg_type, msg_sop, msg_info, pe_ack, flush, err_clr,
        output pl2pe_rx_en, pl2pe_rx_type, pl2pe_rx_sop_type, pl2pe_rx_info,
        output q_count, ovf_err, drop_cnt
    );
endinterface
`default_nettype wire

// File: rtl/prl_rx_pe_dispatch.sv
`default_nettype none
// ============================================================================
// prl_rx_pe_dispatch
// Queues parsed PRL RX messages and presents them one at a time to the PE.
// Revision: 1.0
// ============================================================================
module prl_rx_pe_dispatch #(
    parameter int DEPTH  = 4,
    parameter int DROP_W = 8
) (
    input  wire logic              clk,
    input  wire logic              rst,
    prl_rx_pe_dispatch_if.slave    bus
);
    localparam int c_PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int c_CNT_W = $clog2(DEPTH) + 1;
    localparam int c_ENT_W = 33;
    localparam logic [6:0] c_SOFT_RESET = 7'h0D;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        VALID = 2'd1,
        GAP   = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [c_PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [c_PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [c_CNT_W-1:0]   count_q, count_d;
    logic [6:0]           type_q, type_d;
    logic [2:0]           sop_q, sop_d;
    logic [22:0]          info_q, info_d;
    logic                 ovf_q, ovf_d;
    logic [DROP_W-1:0]    drop_q, drop_d;
    logic [c_ENT_W-1:0]   mem_q [DEPTH];

    logic                 w_soft;
    logic                 w_full;
    logic                 w_pop;
    logic                 w_push;
    logic                 w_drop;
    logic                 w_wr_en;
    logic [c_PTR_W-1:0]   w_wr_addr;
    logic [c_ENT_W-1:0]   w_wr_data;
    logic [c_ENT_W-1:0]   w_head;
    logic [DROP_W-1:0]    w_drop_base;

    assign w_soft    = bus.msg_vld && (bus.msg_type == c_SOFT_RESET);
    assign w_full    = (count_q == c_CNT_W'(DEPTH));
    assign w_wr_data = {bus.msg_type, bus.msg_sop, bus.msg_info};
    assign w_head    = mem_q[rd_ptr_q];

    always_comb begin
        state_d     = state_q;
        rd_ptr_d    = rd_ptr_q;
        wr_ptr_d    = wr_ptr_q;
        count_d     = count_q;
        type_d      = type_q;
        sop_d       = sop_q;
        info_d      = info_q;
        ovf_d       = ovf_q;
        drop_d      = drop_q;
        w_pop       = 1'b0;
        w_push      = 1'b0;
        w_drop      = 1'b0;
        w_wr_en     = 1'b0;
        w_wr_addr   = wr_ptr_q;
        w_drop_base = bus.err_clr ? '0 : drop_q;

        if (bus.err_clr) begin
            ovf_d  = 1'b0;
            drop_d = '0;
        end

        if (bus.flush || w_soft) begin
            // Queue restarts from slot 0; a message on this edge becomes the sole entry.
            state_d  = IDLE;
            rd_ptr_d = '0;
            if (bus.msg_vld) begin
                w_wr_en   = 1'b1;
                w_wr_addr = '0;
                wr_ptr_d  = c_PTR_W'(1 % DEPTH);
                count_d   = c_CNT_W'(1);
            end else begin
                wr_ptr_d = '0;
                count_d  = '0;
            end
        end else begin
            w_pop  = (state_q == VALID) && bus.pe_ack;
            w_push = bus.msg_vld && (!w_full || w_pop);
            w_drop = bus.msg_vld && w_full && !w_pop;

            if (w_push) begin
                w_wr_en  = 1'b1;
                wr_ptr_d = wr_ptr_q + c_PTR_W'(1);
            end
            if (w_pop) begin
                rd_ptr_d = rd_ptr_q + c_PTR_W'(1);
            end
            count_d = count_q + c_CNT_W'(w_push) - c_CNT_W'(w_pop);

            case (state_q)
                IDLE, GAP: begin
                    if (count_q != '0) begin
                        state_d = VALID;
                        {type_d, sop_d, info_d} = w_head;
                    end else begin
                        state_d = IDLE;
                    end
                end
                VALID: begin
                    if (bus.pe_ack) begin
                        state_d = GAP;
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        if (w_drop) begin
            ovf_d  = 1'b1;
            drop_d = (&w_drop_base) ? w_drop_base : w_drop_base + DROP_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            type_q   <= '0;
            sop_q    <= '0;
            info_q   <= '0;
            ovf_q    <= 1'b0;
            drop_q   <= '0;
        end else begin
            state_q  <= state_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            type_q   <= type_d;
            sop_q    <= sop_d;
            info_q   <= info_d;
            ovf_q    <= ovf_d;
            drop_q   <= drop_d;
        end
    end

    // Storage is never cleared; only the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (!rst && w_wr_en) begin
            mem_q[w_wr_addr] <= w_wr_data;
        end
    end

    assign bus.pl2pe_rx_en       = (state_q == VALID);
    assign bus.pl2pe_rx_type     = type_q;
    assign bus.pl2pe_rx_sop_type = sop_q;
    assign bus.pl2pe_rx_info     = info_q;
    assign bus.q_count           = count_q;
    assign bus.ovf_err           = ovf_q;
    assign bus.drop_cnt          = drop_q;

endmodule
`default_nettype wire

// File: doc/prl_rx_pe_dispatch.md
PRL_RX_PE_DISPATCH -- requirements
Module: prl_rx_pe_dispatch

Interface
REQ-001 SHALL provide the parameter DEPTH, default 4, queue depth in messages (power of two, 2..8).
REQ-002 SHALL provide the parameter DROP_W, default 8, width of the dropped-message counter.
REQ-003 SHALL have a single clock and a synchronous, active-high reset: clk is the one clock; rst is synchronous, active-high.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 rst  input  1  synchronous active-high reset.
REQ-006 msg_vld  input  1  one-cycle strobe from the PRL RX state machine that a parsed message is ready.
REQ-007 msg_type  input  7  {message_type[1:0], header_type[4:0]}.
REQ-008 msg_sop  input  3  SOP type of the message.
REQ-009 msg_info  input  23  packed info word (bist_mode, pdo_type, mismatch, op_cur, max_op_cur).
REQ-010 pe_ack  input  1  PE has consumed the presented message.
REQ-011 flush  input  1  hard reset or cable reset seen; discard all queued messages.
REQ-012 err_clr  input  1  clears ovf_err.
REQ-013 pl2pe_rx_en  output  1  a message is presented to the PE (level).
REQ-014 pl2pe_rx_type  output  7  type of the presented message.
REQ-015 pl2pe_rx_sop_type  output  3  SOP of the presented message.
REQ-016 pl2pe_rx_info  output  23  info of the presented message.
REQ-017 q_count  output  clog2(DEPTH)+1  number of messages queued, including the presented one.
REQ-018 ovf_err  output  1  sticky flag: a message was dropped because the queue was full.
REQ-019 drop_cnt  output  DROP_W  saturating count of dropped messages.

Function
REQ-020 SHALL store each message as a 33-bit entry {type, sop, info} in a circular FIFO of DEPTH entries, with read and write pointers wrapping modulo DEPTH.
REQ-021 SHALL write the entry on the rising edge where msg_vld=1 and the queue is not full, and increment q_count on that edge.
REQ-022 SHALL implement the FSM states IDLE, VALID and GAP; pl2pe_rx_en=1 only in VALID.
REQ-023 IDLE -> VALID when q_count!=0; on that edge the FSM loads the head entry into the pl2pe_rx_type/sop_type/info registers.
REQ-024 Latency: a message strobed into an empty IDLE queue at edge k SHALL show pl2pe_rx_en=1 after edge k+1.
REQ-025 VALID: the FSM holds the outputs stable until pe_ack=1; on that edge it pops the head and goes to GAP.
REQ-026 GAP: pl2pe_rx_en=0 for exactly one cycle; the FSM then goes to VALID, loading the new head, if q_count!=0, else to IDLE.
REQ-027 pe_ack SHALL be ignored in IDLE and GAP.
REQ-028 The type/sop/info outputs SHALL hold their last values when pl2pe_rx_en=0.
REQ-029 Push and pop on the same edge SHALL both take effect, leaving q_count unchanged.
REQ-030 Full queue (q_count=DEPTH), msg_vld=1, no pop: the message SHALL be dropped, ovf_err set, and drop_cnt incremented, saturating at all-ones.
REQ-031 Full queue with msg_vld and pop on the same edge: the message SHALL be accepted.
REQ-032 Soft_Reset message (msg_type=7'h0D) accepted by msg_vld: all older entries SHALL be discarded, the Soft_Reset stored as the sole entry (q_count=1), and the FSM forced to IDLE; a presentation in progress is aborted without pop, even if pe_ack=1 on that edge.
REQ-033 A Soft_Reset message SHALL never be dropped for full, because it flushes first.
REQ-034 flush=1: the FIFO SHALL be emptied, the pointers zeroed and the FSM forced to IDLE; pe_ack on that edge is ignored.
REQ-035 flush and msg_vld on the same edge: the queue SHALL be emptied, then the new message stored (q_count=1).
REQ-036 Priority SHALL be rst > flush/Soft_Reset > pop/push.
REQ-037 err_clr SHALL clear ovf_err and drop_cnt; if a drop occurs on the same edge, the drop wins (ovf_err=1, drop_cnt=1).

Reset
REQ-038 On rst=1 at a clock edge, the FSM SHALL go to IDLE, pointers to 0, q_count=0, pl2pe_rx_en=0, type/sop/info=0, ovf_err=0 and drop_cnt=0; FIFO storage need not be cleared.
REQ-039 rst SHALL override every other input on the same edge, including mid-presentation.

Verification
REQ-040 Single msg: msg_vld at edge 0 with type 7'h42, sop 0, info 23'h12345 -> pl2pe_rx_en=1 after edge 1 carrying those values, held until pe_ack; after the ack edge, en=0 and q_count=0.
REQ-041 Back-to-back: 3 strobes on consecutive cycles, then ack each in turn -> messages delivered in order, each separated by exactly one en=0 GAP cycle.
REQ-042 Overflow (DEPTH=4): 5 strobes with no ack -> q_count=4, ovf_err=1, drop_cnt=1, and the 5th message is never delivered; err_clr then gives ovf_err=0, drop_cnt=0.
REQ-043 Full plus simultaneous ack and push -> q_count stays 4 and ovf_err stays 0.
REQ-044 Soft_Reset while VALID with 3 queued -> after the edge, q_count=1; the next presentation is type 7'h0D after 1 IDLE cycle.
REQ-045 flush with msg_vld on the same edge while 2 are queued -> q_count=1 and only the new message is delivered; rst asserted mid-VALID -> all outputs 0 next cycle.
